// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin sharing of one sin/cos CORDIC engine.
// Each job runs grant, start pulse, then waits for done or a timeout, then an idle gap.
module cordic_arbiter #(
    parameter int N_REQ    = 3,
    parameter int IDLE_GAP = 2,
    parameter int TIMEOUT  = 63
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic [N_REQ-1:0]        iReq,
    input  logic [20*N_REQ-1:0]     iTheta,
    output logic [N_REQ-1:0]        oAck,
    output logic signed [15:0]      oSin,
    output logic signed [15:0]      oCos,
    output logic                    oErr,
    output logic                    oBusy,
    output logic                    oCordic_en,
    output logic [19:0]             oCordic_theta,
    input  logic signed [15:0]      iCordic_sin,
    input  logic signed [15:0]      iCordic_cos,
    input  logic                    iCordic_done
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   grant;
    logic [7:0]      wait_cnt;
    logic [3:0]      gap_cnt;

    logic [IW-1:0]   pick;
    logic            hit;
    logic [19:0]     theta_pick;
    int              idx;

    // Round-robin search: first pending requester after the last one granted.
    always_comb begin
        pick       = '0;
        hit        = 1'b0;
        theta_pick = '0;
        idx        = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!hit && iReq[idx]) begin
                hit        = 1'b1;
                pick       = IW'(idx);
                theta_pick = iTheta[idx*20 +: 20];
            end
        end
    end

    assign oBusy = (state != IDLE);

    // Job sequencer; all handshake outputs are registered here.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state         <= GAP;
            ptr           <= IW'(N_REQ - 1);
            grant         <= '0;
            wait_cnt      <= '0;
            gap_cnt       <= 4'(IDLE_GAP);
            oAck          <= '0;
            oSin          <= '0;
            oCos          <= '0;
            oErr          <= 1'b0;
            oCordic_en    <= 1'b0;
            oCordic_theta <= '0;
        end else begin
            oAck       <= '0;
            oErr       <= 1'b0;
            oCordic_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        oCordic_theta <= theta_pick;
                        grant         <= pick;
                        ptr           <= pick;
                        oCordic_en    <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // Done wins over a timeout landing in the same cycle.
                    if (iCordic_done) begin
                        oSin    <= iCordic_sin;
                        oCos    <= iCordic_cos;
                        oAck    <= N_REQ'(1) << grant;
                        gap_cnt <= 4'(IDLE_GAP);
                        state   <= GAP;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        oSin    <= '0;
                        oCos    <= '0;
                        oAck    <= N_REQ'(1) << grant;
                        oErr    <= 1'b1;
                        gap_cnt <= 4'(IDLE_GAP);
                        state   <= GAP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                GAP: begin
                    // Engine is edge triggered; hold off the next start.
                    if (gap_cnt <= 4'd1) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: directed checks of cordic_arbiter with a hand-driven engine stub.
// Latencies and values below are derived by hand for N_REQ=3, IDLE_GAP=2, TIMEOUT=63.
module tb_cordic_arbiter;

    localparam int N_REQ    = 3;
    localparam int IDLE_GAP = 2;
    localparam int TIMEOUT  = 63;

    logic                iClk;
    logic                iRst;
    logic [N_REQ-1:0]    iReq;
    logic [20*N_REQ-1:0] iTheta;
    logic [N_REQ-1:0]    oAck;
    logic signed [15:0]  oSin;
    logic signed [15:0]  oCos;
    logic                oErr;
    logic                oBusy;
    logic                oCordic_en;
    logic [19:0]         oCordic_theta;
    logic signed [15:0]  iCordic_sin;
    logic signed [15:0]  iCordic_cos;
    logic                iCordic_done;

    int errors = 0;
    int checks = 0;

    cordic_arbiter #(
        .N_REQ(N_REQ),
        .IDLE_GAP(IDLE_GAP),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .iClk(iClk),
        .iRst(iRst),
        .iReq(iReq),
        .iTheta(iTheta),
        .oAck(oAck),
        .oSin(oSin),
        .oCos(oCos),
        .oErr(oErr),
        .oBusy(oBusy),
        .oCordic_en(oCordic_en),
        .oCordic_theta(oCordic_theta),
        .iCordic_sin(iCordic_sin),
        .iCordic_cos(iCordic_cos),
        .iCordic_done(iCordic_done)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    localparam logic [19:0] T0 = 20'h00001;
    localparam logic [19:0] T1 = 20'h40000;
    localparam logic [19:0] T2 = 20'h80003;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for the start pulse, plays the engine, checks the ack cycle.
    // delay<0 means the engine never answers (timeout path).
    task automatic run_job(input string tag, input int g,
                           input logic [19:0] th, input int delay,
                           input logic signed [15:0] s,
                           input logic signed [15:0] c,
                           input bit drop_at_en, input bit keep,
                           output int waited);
        int n;
        int ens;
        int acks;
        logic [N_REQ-1:0] exp_ack;
        logic signed [15:0] es;
        logic signed [15:0] ec;
        waited = 0;
        while (!oCordic_en && waited < 20) begin
            tick();
            waited++;
        end
        chk({tag, "_en"}, 32'(oCordic_en), 32'd1);
        chk({tag, "_theta"}, 32'(oCordic_theta), 32'(th));
        if (drop_at_en) iReq[g] = 1'b0;
        n = (delay < 0) ? TIMEOUT : delay;
        ens = 0;
        acks = 0;
        repeat (n) begin
            tick();
            if (oCordic_en) ens++;
            if (oAck != '0) acks++;
        end
        chk({tag, "_extra_en"}, 32'(ens), 32'd0);
        chk({tag, "_early_ack"}, 32'(acks), 32'd0);
        if (delay >= 0) begin
            iCordic_done = 1'b1;
            iCordic_sin  = s;
            iCordic_cos  = c;
        end
        tick();
        iCordic_done = 1'b0;
        exp_ack = N_REQ'(1) << g;
        es = (delay < 0) ? 16'sd0 : s;
        ec = (delay < 0) ? 16'sd0 : c;
        chk({tag, "_ack"}, 32'(oAck), 32'(exp_ack));
        chk({tag, "_err"}, 32'(oErr), (delay < 0) ? 32'd1 : 32'd0);
        chk({tag, "_sin"}, 32'(oSin), 32'(es));
        chk({tag, "_cos"}, 32'(oCos), 32'(ec));
        if (!keep) iReq[g] = 1'b0;
        tick();
        chk({tag, "_ack_pulse"}, 32'(oAck), 32'd0);
        chk({tag, "_err_pulse"}, 32'(oErr), 32'd0);
        chk({tag, "_sin_hold"}, 32'(oSin), 32'(es));
    endtask

    initial begin
        int w;
        int acks;
        int ens;
        iRst = 1'b1;
        iReq = '0;
        iTheta = '0;
        iCordic_done = 1'b0;
        iCordic_sin = '0;
        iCordic_cos = '0;
        repeat (3) tick();

        chk("rst_ack", 32'(oAck), 32'd0);
        chk("rst_sin", 32'(oSin), 32'd0);
        chk("rst_cos", 32'(oCos), 32'd0);
        chk("rst_err", 32'(oErr), 32'd0);
        chk("rst_en", 32'(oCordic_en), 32'd0);
        chk("rst_theta", 32'(oCordic_theta), 32'd0);
        chk("rst_busy", 32'(oBusy), 32'd1);

        // Single request from requester 1.
        iTheta = {T2, T1, T0};
        iReq = 3'b010;
        iRst = 1'b0;
        chk("post_rst_busy0", 32'(oBusy), 32'd1);
        tick();
        chk("post_rst_busy1", 32'(oBusy), 32'd1);
        chk("post_rst_en1", 32'(oCordic_en), 32'd0);
        tick();
        chk("post_rst_idle", 32'(oBusy), 32'd0);
        run_job("single", 1, T1, 20, 16'sd0, -16'sd32767, 1'b0, 1'b0, w);
        chk("single_wait", 32'(w), 32'd1);

        // Round robin from fresh reset: 0,1,2,0.
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        iReq = 3'b111;
        run_job("rr0", 0, T0, 3, 16'sd11, 16'sd12, 1'b0, 1'b1, w);
        run_job("rr1", 1, T1, 4, 16'sd21, 16'sd22, 1'b0, 1'b1, w);
        chk("rr1_gap", 32'(w), 32'd2);
        run_job("rr2", 2, T2, 5, 16'sd31, 16'sd32, 1'b0, 1'b1, w);
        chk("rr2_gap", 32'(w), 32'd2);
        run_job("rr3", 0, T0, 6, 16'sd41, -16'sd42, 1'b0, 1'b1, w);
        chk("rr3_gap", 32'(w), 32'd2);

        // Timeout on requester 1, then requester 0 served normally.
        iReq = 3'b011;
        run_job("tmo", 1, T1, -1, 16'sd0, 16'sd0, 1'b0, 1'b0, w);
        run_job("after_tmo", 0, T0, 5, 16'sd100, 16'sd200, 1'b0, 1'b0, w);
        chk("after_tmo_gap", 32'(w), 32'd2);

        // Done on the last WAIT cycle wins over timeout.
        iReq = 3'b001;
        run_job("collide", 0, T0, TIMEOUT, -16'sd5, 16'sd7, 1'b0, 1'b0, w);

        // Requester 2 withdraws right after grant; ack still issued.
        iReq = 3'b100;
        run_job("withdraw", 2, T2, 4, 16'sd1234, -16'sd1234, 1'b1, 1'b0, w);

        // Spurious done in GAP/IDLE is ignored.
        iCordic_done = 1'b1;
        iCordic_sin = 16'sd555;
        iCordic_cos = 16'sd555;
        acks = 0;
        ens = 0;
        repeat (4) begin
            tick();
            if (oAck != '0) acks++;
            if (oCordic_en) ens++;
        end
        iCordic_done = 1'b0;
        chk("spur_ack", 32'(acks), 32'd0);
        chk("spur_en", 32'(ens), 32'd0);
        chk("spur_sin", 32'(oSin), 32'(16'sd1234));
        chk("spur_idle", 32'(oBusy), 32'd0);

        // Reset in the middle of WAIT.
        iReq = 3'b010;
        w = 0;
        while (!oCordic_en && w < 20) begin
            tick();
            w++;
        end
        chk("mid_en", 32'(oCordic_en), 32'd1);
        repeat (5) tick();
        iRst = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(oAck), 32'd0);
        chk("mid_rst_sin", 32'(oSin), 32'd0);
        chk("mid_rst_cos", 32'(oCos), 32'd0);
        chk("mid_rst_theta", 32'(oCordic_theta), 32'd0);
        chk("mid_rst_busy", 32'(oBusy), 32'd1);
        iReq = 3'b011;
        tick();
        iRst = 1'b0;
        chk("rel_busy0", 32'(oBusy), 32'd1);
        chk("rel_en0", 32'(oCordic_en), 32'd0);
        tick();
        chk("rel_busy1", 32'(oBusy), 32'd1);
        chk("rel_en1", 32'(oCordic_en), 32'd0);
        run_job("rel", 0, T0, 2, 16'sd9, -16'sd9, 1'b0, 1'b0, w);
        chk("rel_wait", 32'(w), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
